// File: rtl/spi_pkg.sv
// Shared types and helpers for the N-byte SPI master.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    // Bits needed to hold counts 0..max_cnt (never narrower than one bit).
    function automatic int unsigned cnt_w(input int unsigned max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period generator: rise/fall strobes mark the clk edge where sclk changes.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_c,
    output logic fall_c,
    output logic sclk
);

    localparam int unsigned HC_W = cnt_w(CLK_DIV - 1);

    logic [HC_W-1:0] hc_q, hc_d;
    logic            sclk_q, sclk_d;
    logic            tick_c;

    // Counter and sclk fall back to idle whenever the divider is disabled.
    always_comb begin
        tick_c = en && (hc_q == HC_W'(CLK_DIV - 1));
        rise_c = tick_c && !sclk_q;
        fall_c = tick_c && sclk_q;
        hc_d   = '0;
        sclk_d = 1'b0;
        if (en) begin
            hc_d   = tick_c ? '0 : hc_q + 1'b1;
            sclk_d = sclk_q ^ tick_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q   <= '0;
            sclk_q <= 1'b0;
        end else begin
            hc_q   <= hc_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_nbyte.sv
// Mode-0 SPI master running one full-duplex NUM_BYTES transaction per accepted start.
module spi_master_nbyte
    import spi_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 5,
    parameter int unsigned CLK_DIV   = 50,
    parameter int unsigned SS_SETUP  = 1000,
    parameter int unsigned BYTE_GAP  = 1000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [SPI_BYTE_W*NUM_BYTES-1:0]   tx_data,
    output logic                              busy,
    output logic                              done,
    output logic [SPI_BYTE_W*NUM_BYTES-1:0]   rx_data,
    output logic                              sclk,
    output logic                              mosi,
    input  logic                              miso,
    output logic                              ss_n
);

    localparam int unsigned W        = SPI_BYTE_W * NUM_BYTES;
    localparam int unsigned BIT_W    = cnt_w(SPI_BYTE_W - 1);
    localparam int unsigned BYTE_W   = cnt_w(NUM_BYTES - 1);
    localparam int unsigned DLY_MAX  = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int unsigned DLY_W    = cnt_w(DLY_MAX - 1);
    localparam int unsigned GAP_LAST = (BYTE_GAP > 0) ? BYTE_GAP - 1 : 0;

    spi_state_t        state_q, state_d;
    logic [W-1:0]      tx_q, tx_d;
    logic [W-1:0]      rx_q, rx_d;
    logic [W-1:0]      rx_data_q, rx_data_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              ss_n_q, ss_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rise_c, fall_c;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == ST_XFER),
        .rise_c (rise_c),
        .fall_c (fall_c),
        .sclk   (sclk)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        dly_d   = dly_q;
        case (state_q)
            // DONE accepts start exactly like IDLE so back-to-back requests lose no cycle.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_SETUP;
                    tx_d    = tx_data;
                    rx_d    = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    dly_d   = '0;
                end
            end
            ST_SETUP: begin
                if (dly_q == DLY_W'(SS_SETUP - 1)) begin
                    state_d = ST_XFER;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (rise_c) rx_d = {rx_q[W-2:0], miso};
                if (fall_c) begin
                    tx_d = {tx_q[W-2:0], 1'b0};
                    if (bit_q == BIT_W'(SPI_BYTE_W - 1)) begin
                        bit_d = '0;
                        if (byte_q == BYTE_W'(NUM_BYTES - 1)) begin
                            state_d = ST_DONE;
                        end else if (BYTE_GAP == 0) begin
                            byte_d = byte_q + 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            dly_d   = '0;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (dly_q == DLY_W'(GAP_LAST)) begin
                    state_d = ST_XFER;
                    dly_d   = '0;
                    byte_d  = byte_q + 1'b1;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d    = (state_d == ST_SETUP) || (state_d == ST_XFER) || (state_d == ST_GAP);
        ss_n_d    = !busy_d;
        done_d    = (state_d == ST_DONE);
        rx_data_d = done_d ? rx_q : rx_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            dly_q     <= '0;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            dly_q     <= dly_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign ss_n    = ss_n_q;
    assign mosi    = tx_q[W-1];

endmodule

// File: tb/tb_spi_master_nbyte.sv
// Self-checking bench: a 5-byte and a 1-byte master against a behavioural mode-0 slave model.
module tb_spi_master_nbyte;

    localparam int unsigned NB = 5;
    localparam int unsigned CD = 2;
    localparam int unsigned SS = 4;
    localparam int unsigned BG = 3;
    localparam int unsigned W  = 8 * NB;
    localparam int          L  = SS + NB * 16 * CD + (NB - 1) * BG;
    localparam int          LM = 1 + 16 * 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_a, start_b;
    logic [W-1:0]  tx_a, rx_a;
    logic [7:0]    tx_b, rx_b;
    logic          busy_a, done_a, sclk_a, mosi_a, miso_a, ss_n_a;
    logic          busy_b, done_b, sclk_b, mosi_b, miso_b, ss_n_b;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] slave_a = '0;
    logic [7:0]   slave_b = '0;
    int           idx_a = 0, idx_b = 0;
    logic         sp_a = 1'b0, sp_b = 1'b0;

    always #5 clk = ~clk;

    spi_master_nbyte #(.NUM_BYTES(NB), .CLK_DIV(CD), .SS_SETUP(SS), .BYTE_GAP(BG)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .busy(busy_a),
        .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .ss_n(ss_n_a)
    );

    spi_master_nbyte #(.NUM_BYTES(1), .CLK_DIV(2), .SS_SETUP(1), .BYTE_GAP(0)) u_min (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .busy(busy_b),
        .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .ss_n(ss_n_b)
    );

    // Mode-0 slave: first bit valid on select, next bit after every sclk fall.
    always @(negedge clk) begin
        if (ss_n_a) idx_a <= 0;
        else if (sp_a && !sclk_a) idx_a <= idx_a + 1;
        sp_a <= sclk_a;
        if (ss_n_b) idx_b <= 0;
        else if (sp_b && !sclk_b) idx_b <= idx_b + 1;
        sp_b <= sclk_b;
    end

    assign miso_a = (idx_a < int'(W)) ? slave_a[W-1-idx_a] : 1'b0;
    assign miso_b = (idx_b < 8) ? slave_b[7-idx_b] : 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the 5-byte master; extra start pulses land at edges p1..p3.
    task automatic run_a(input logic [W-1:0] tx, input logic [W-1:0] sw,
                         input int p1, input int p2, input int p3, input string tag);
        int ss_low, ss_first, ss_last, busy_cnt, done_cnt, done_at, rises, viol;
        logic [W-1:0] mword, rx_at_done;
        logic sp, mp, ssp;
        ss_low = 0; ss_first = 0; ss_last = 0; busy_cnt = 0; done_cnt = 0;
        done_at = 0; rises = 0; viol = 0; mword = '0; rx_at_done = '0;
        slave_a = sw;
        @(negedge clk);
        tx_a    = tx;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        tx_a    = ~tx;
        sp = sclk_a; mp = mosi_a; ssp = ss_n_a;
        for (int c = 1; c <= L + 3; c++) begin
            @(negedge clk);
            start_a = (c == p1) || (c == p2) || (c == p3);
            if (!ss_n_a) begin
                ss_low++;
                if (ss_first == 0) ss_first = c;
                ss_last = c;
            end
            if (busy_a) busy_cnt++;
            if (done_a) begin
                done_cnt++;
                done_at    = c;
                rx_at_done = rx_a;
            end
            if (!sp && sclk_a) begin
                rises++;
                mword = {mword[W-2:0], mosi_a};
            end
            if ((mosi_a !== mp) && !ssp && !ss_n_a && !(sp && !sclk_a)) viol++;
            sp = sclk_a; mp = mosi_a; ssp = ss_n_a;
        end
        start_a = 1'b0;
        chk({tag, ".ss_low_cnt"}, 64'(ss_low), 64'(L));
        chk({tag, ".ss_first"},   64'(ss_first), 64'd1);
        chk({tag, ".ss_last"},    64'(ss_last), 64'(L));
        chk({tag, ".busy_cnt"},   64'(busy_cnt), 64'(L));
        chk({tag, ".done_cnt"},   64'(done_cnt), 64'd1);
        chk({tag, ".done_at"},    64'(done_at), 64'(L + 1));
        chk({tag, ".rx_at_done"}, 64'(rx_at_done), 64'(sw));
        chk({tag, ".rx_held"},    64'(rx_a), 64'(sw));
        chk({tag, ".sclk_rises"}, 64'(rises), 64'(W));
        chk({tag, ".mosi_word"},  64'(mword), 64'(tx));
        chk({tag, ".mosi_edges"}, 64'(viol), 64'd0);
    endtask

    initial begin
        logic [W-1:0] tx, sw;
        int d1, d2, dcnt, ss_l1, ss_l2, ss_low, done_at, rises;
        logic [7:0] mb;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; tx_a = '0; tx_b = '0;
        repeat (3) @(negedge clk);
        chk("reset.ss_n",  64'(ss_n_a), 64'd1);
        chk("reset.sclk",  64'(sclk_a), 64'd0);
        chk("reset.mosi",  64'(mosi_a), 64'd0);
        chk("reset.busy",  64'(busy_a), 64'd0);
        chk("reset.done",  64'(done_a), 64'd0);
        chk("reset.rx",    64'(rx_a), 64'd0);
        chk("reset.min_ss_n", 64'(ss_n_b), 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_a(W'({$urandom, $urandom}), 40'hA1B2C3D4E5, 0, 0, 0, "nominal");
        run_a(40'h80_00_00_00_01, W'({$urandom, $urandom}), 0, 0, 0, "mosi_order");
        run_a(W'({$urandom, $urandom}), W'({$urandom, $urandom}), 1, 50, 176, "start_busy");
        run_a(W'({$urandom, $urandom}), W'({$urandom, $urandom}), 0, 0, 0, "random");

        // Back-to-back: start held through the first DONE cycle.
        tx = W'({$urandom, $urandom});
        sw = W'({$urandom, $urandom});
        slave_a = sw;
        @(negedge clk);
        tx_a = tx;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        d1 = 0; d2 = 0; dcnt = 0; ss_l1 = 0; ss_l2 = 1;
        for (int c = 1; c <= 2 * L + 4; c++) begin
            @(negedge clk);
            if (c == L + 2) start_a = 1'b0;
            if (c == L + 1) ss_l1 = int'(ss_n_a);
            if (c == L + 2) ss_l2 = int'(ss_n_a);
            if (done_a) begin
                dcnt++;
                if (dcnt == 1) d1 = c;
                if (dcnt == 2) d2 = c;
            end
        end
        chk("b2b.done1_at", 64'(d1), 64'(L + 1));
        chk("b2b.done2_at", 64'(d2), 64'(2 * L + 2));
        chk("b2b.done_cnt", 64'(dcnt), 64'd2);
        chk("b2b.ss_n_done", 64'(ss_l1), 64'd1);
        chk("b2b.ss_n_restart", 64'(ss_l2), 64'd0);
        chk("b2b.rx", 64'(rx_a), 64'(sw));

        // Asynchronous reset in the middle of byte 2.
        slave_a = W'({$urandom, $urandom});
        @(negedge clk);
        tx_a = W'({$urandom, $urandom});
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (80) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.ss_n", 64'(ss_n_a), 64'd1);
        chk("midrst.sclk", 64'(sclk_a), 64'd0);
        chk("midrst.rx",   64'(rx_a), 64'd0);
        chk("midrst.busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_a(W'({$urandom, $urandom}), W'({$urandom, $urandom}), 0, 0, 0, "post_reset");

        // Minimal configuration on the 1-byte master.
        slave_b = 8'h5A;
        @(negedge clk);
        tx_b = 8'($urandom);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        ss_low = 0; done_at = 0; rises = 0; mb = '0;
        for (int c = 1; c <= LM + 3; c++) begin
            logic sp;
            sp = sclk_b;
            @(negedge clk);
            if (!ss_n_b) ss_low++;
            if (done_b) done_at = c;
            if (!sp && sclk_b) begin
                rises++;
                mb = {mb[6:0], mosi_b};
            end
        end
        chk("min.done_at", 64'(done_at), 64'(LM + 1));
        chk("min.rx", 64'(rx_b), 64'h5A);
        chk("min.ss_low_cnt", 64'(ss_low), 64'(LM));
        chk("min.sclk_rises", 64'(rises), 64'd8);
        chk("min.mosi_word", 64'(mb), 64'(tx_b));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
